// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction memory port, redirect, and decode handshake.
// master = fetch_queue side, slave = memory/decode/branch-unit side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     imem_req;
  logic [31:0]              imem_addr;
  logic [31:0]              imem_rdata;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [31:0]              instr_out;
  logic [31:0]              pc_out;
  logic                     misalign;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out, misalign, occupancy,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out, misalign, occupancy,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues synchronous imem reads
// and buffers {pc, instr} pairs in a DEPTH-entry FIFO toward decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master fq
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic          pending;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] credit;
  logic          req;
  logic          push;
  logic          pop;
  logic          misalign_q;

  // An outstanding read already owns a slot; a same-cycle pop is not credited.
  assign credit = {1'b0, count} + {{(AW + 1){1'b0}}, pending};
  assign req    = rst_n && !fq.redirect_valid && (credit < (AW + 2)'(DEPTH));
  assign push   = pending && !fq.redirect_valid;
  assign pop    = fq.instr_valid && fq.instr_ready;

  assign fq.imem_req    = req;
  assign fq.imem_addr   = fetch_pc;
  assign fq.instr_valid = (count != '0);
  assign fq.instr_out   = fq.instr_valid ? mem_instr[rd_ptr] : '0;
  assign fq.pc_out      = fq.instr_valid ? mem_pc[rd_ptr] : '0;
  assign fq.occupancy   = count;
  assign fq.misalign    = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      pend_pc    <= '0;
      pending    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misalign_q <= 1'b0;
    end else if (fq.redirect_valid) begin
      fetch_pc   <= {fq.redirect_pc[31:2], 2'b00};
      pending    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misalign_q <= |fq.redirect_pc[1:0];
    end else begin
      misalign_q <= 1'b0;
      pending    <= req;
      if (req) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pend_pc;
      mem_instr[wr_ptr] <= fq.imem_rdata;
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && count == (AW + 1)'(DEPTH)));
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized phase
// checked against a queue-based reference model of the fetch stream.
module tb_fetch_queue;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RPC2   = 32'hFFFF_FFF8;

  logic clk;
  logic rst_n;
  logic rst2_n;
  int   checks;
  int   failures;

  fetch_queue_if #(.DEPTH(DEPTH)) f1 ();
  fetch_queue_if #(.DEPTH(DEPTH)) f2 ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut1 (.clk(clk), .rst_n(rst_n),  .fq(f1));
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC2))  dut2 (.clk(clk), .rst_n(rst2_n), .fq(f2));

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(logic [31:0] a);
    case (a)
      32'h0:   return 32'h0020_81B3;
      32'h4:   return 32'h0020_8463;
      32'h8:   return 32'h0041_8233;
      32'hC:   return 32'h0052_0293;
      32'h10:  return 32'h0100_006F;
      default: return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endcase
  endfunction

  always @(posedge clk) if (f1.imem_req) f1.imem_rdata <= word_at(f1.imem_addr);
  always @(posedge clk) if (f2.imem_req) f2.imem_rdata <= word_at(f2.imem_addr);

  // Reference model: FIFO contents as a queue of fetch addresses.
  logic [31:0] q_pc [$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_pend_pc;
  logic        m_pending;
  logic        m_mis;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_req();
    return rst_n && !f1.redirect_valid && (q_pc.size() + int'(m_pending) < DEPTH);
  endfunction

  task automatic model_reset();
    q_pc.delete();
    m_fetch_pc = 32'h0;
    m_pend_pc  = 32'h0;
    m_pending  = 1'b0;
    m_mis      = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    chk("req", 32'(f1.imem_req), 32'(model_req()));
    if (model_req()) chk("addr", f1.imem_addr, m_fetch_pc);
    chk("valid", 32'(f1.instr_valid), 32'(q_pc.size() != 0));
    chk("occ", 32'(f1.occupancy), 32'(q_pc.size()));
    chk("misalign", 32'(f1.misalign), 32'(m_mis));
    if (q_pc.size() != 0) begin
      chk("pc_out", f1.pc_out, q_pc[0]);
      chk("instr_out", f1.instr_out, word_at(q_pc[0]));
    end
  endtask

  task automatic tick();
    logic r;
    r = model_req();
    if (rst_n) begin
      if (f1.redirect_valid) begin
        q_pc.delete();
        m_pending  = 1'b0;
        m_fetch_pc = {f1.redirect_pc[31:2], 2'b00};
        m_mis      = |f1.redirect_pc[1:0];
      end else begin
        m_mis = 1'b0;
        if (q_pc.size() != 0 && f1.instr_ready) void'(q_pc.pop_front());
        if (m_pending) q_pc.push_back(m_pend_pc);
        if (r) begin
          m_pend_pc  = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
        m_pending = r;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      sample();
      tick();
    end
  endtask

  task automatic do_reset(logic rdy);
    rst_n             = 1'b0;
    f1.instr_ready    = rdy;
    f1.redirect_valid = 1'b0;
    f1.redirect_pc    = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int nreq;
    checks = 0;
    failures = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    f1.imem_rdata = 32'h0;
    f2.imem_rdata = 32'h0;
    f2.instr_ready = 1'b1;
    f2.redirect_valid = 1'b0;
    f2.redirect_pc = 32'h0;
    f1.instr_ready = 1'b1;
    f1.redirect_valid = 1'b0;
    f1.redirect_pc = 32'h0;
    #12;
    chk("rst_valid", 32'(f1.instr_valid), 32'h0);
    chk("rst_req", 32'(f1.imem_req), 32'h0);
    chk("rst_occ", 32'(f1.occupancy), 32'h0);
    chk("rst_pc_out", f1.pc_out, 32'h0);
    chk("rst_instr_out", f1.instr_out, 32'h0);

    // 1: streaming from reset
    do_reset(1'b1);
    sample(); chk("s1_req0", 32'(f1.imem_req), 32'h1); chk("s1_addr0", f1.imem_addr, 32'h0); tick();
    sample(); chk("s1_valid1", 32'(f1.instr_valid), 32'h0); tick();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("s1_valid", 32'(f1.instr_valid), 32'h1);
      chk("s1_pc", f1.pc_out, 32'(i * 4));
      tick();
    end

    // 2: decode stalled from reset fills exactly DEPTH
    do_reset(1'b0);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (f1.imem_req) nreq++;
      tick();
    end
    chk("s2_nreq", 32'(nreq), 32'd4);
    sample(); chk("s2_occ", 32'(f1.occupancy), 32'd4); chk("s2_req", 32'(f1.imem_req), 32'h0); tick();
    f1.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("s2_pop_valid", 32'(f1.instr_valid), 32'h1);
      chk("s2_pop_pc", f1.pc_out, 32'(i * 4));
      if (i == 0) chk("s2_no_credit", 32'(f1.imem_req), 32'h0);
      if (i == 1) chk("s2_next_addr", f1.imem_addr, 32'h10);
      tick();
    end

    // 3: redirect with occupancy=3 and a read in flight
    do_reset(1'b0);
    run(4);
    f1.redirect_valid = 1'b1;
    f1.redirect_pc = 32'h4;
    sample(); chk("s3_occ_before", 32'(f1.occupancy), 32'd3); tick();
    f1.redirect_valid = 1'b0;
    sample();
    chk("s3_occ", 32'(f1.occupancy), 32'h0);
    chk("s3_valid", 32'(f1.instr_valid), 32'h0);
    chk("s3_addr", f1.imem_addr, 32'h4);
    tick();
    f1.instr_ready = 1'b1;
    sample(); tick();
    sample(); chk("s3_pc", f1.pc_out, 32'h4); tick();

    // 4: misaligned redirect
    f1.redirect_valid = 1'b1;
    f1.redirect_pc = 32'h0000_0013;
    sample(); tick();
    f1.redirect_valid = 1'b0;
    sample(); chk("s4_mis", 32'(f1.misalign), 32'h1); chk("s4_addr", f1.imem_addr, 32'h10); tick();
    sample(); chk("s4_mis_clr", 32'(f1.misalign), 32'h0); tick();
    sample(); chk("s4_pc", f1.pc_out, 32'h10); tick();

    // 5: PC wrap on the second instance
    @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s5_valid", 32'(f2.instr_valid), 32'h1);
      chk("s5_pc", f2.pc_out, RPC2 + 32'(i * 4));
      chk("s5_instr", f2.instr_out, word_at(RPC2 + 32'(i * 4)));
    end
    rst2_n = 1'b0;
    f1.instr_ready = 1'b1;
    @(posedge clk); #1;
    model_reset();
    do_reset(1'b0);

    // 6: asynchronous reset mid-stream
    run(3);
    sample(); chk("s6_occ_before", 32'(f1.occupancy), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_valid", 32'(f1.instr_valid), 32'h0);
    chk("s6_occ", 32'(f1.occupancy), 32'h0);
    chk("s6_req", 32'(f1.imem_req), 32'h0);
    do_reset(1'b1);
    run(2);
    sample(); chk("s6_first_pc", f1.pc_out, 32'h0); chk("s6_first_valid", 32'(f1.instr_valid), 32'h1); tick();

    // randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      f1.instr_ready = ($urandom_range(0, 3) != 0);
      f1.redirect_valid = ($urandom_range(0, 15) == 0);
      f1.redirect_pc = $urandom;
      sample();
      tick();
    end
    f1.redirect_valid = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
